// File: rtl/ace_snoop_buffer.sv
// ACE snoop-path register stage: independent AC/CD/CR FIFOs with an optional
// limiter on snoops accepted on AC but not yet answered on CR.

package ace_snoop_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  snoop;
    logic [2:0]  prot;
  } ac_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } cd_chan_t;

  typedef struct packed {
    logic [4:0] resp;
  } cr_chan_t;

  typedef struct packed {
    ac_chan_t ac;
    logic     ac_valid;
    logic     cd_ready;
    logic     cr_ready;
  } snoop_req_t;

  typedef struct packed {
    logic     ac_ready;
    cd_chan_t cd;
    logic     cd_valid;
    cr_chan_t cr_resp;
    logic     cr_valid;
  } snoop_resp_t;
endpackage

module ace_snoop_fifo #(
  parameter int unsigned Depth = 2,
  parameter type         T     = logic
) (
  input  logic clk,
  input  logic rst,
  input  logic push_valid,
  output logic push_ready,
  input  T     push_data,
  output logic pop_valid,
  input  logic pop_ready,
  output T     pop_data,
  output logic empty
);
  if (Depth == 0) begin : g_pass
    logic unused;
    assign unused     = clk ^ rst;
    assign push_ready = pop_ready;
    assign pop_valid  = push_valid;
    assign pop_data   = push_data;
    assign empty      = 1'b1;
  end else begin : g_fifo
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] Full    = CntW'(Depth);

    // Storage rounded up to a power of two so the pointer indexes it exactly;
    // pointers wrap at Depth-1, so the spare entries are never addressed.
    T                mem [1 << PtrW];
    logic [PtrW-1:0] wr_ptr, rd_ptr;
    logic [CntW-1:0] fill;
    logic            push, pop;

    function automatic logic [PtrW-1:0] wrap_inc(input logic [PtrW-1:0] p);
      return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    // Ready depends only on registered occupancy, so a pop never frees a slot
    // in the same cycle; this keeps ready_i and ready_o decoupled.
    assign push_ready = (fill != Full);
    assign pop_valid  = (fill != '0);
    assign empty      = (fill == '0);
    assign pop_data   = mem[rd_ptr];
    assign push       = push_valid && push_ready;
    assign pop        = pop_valid && pop_ready;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        fill   <= '0;
      end else begin
        if (push) wr_ptr <= wrap_inc(wr_ptr);
        if (pop)  rd_ptr <= wrap_inc(rd_ptr);
        case ({push, pop})
          2'b10:   fill <= fill + 1'b1;
          2'b01:   fill <= fill - 1'b1;
          default: fill <= fill;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
    end
  end
endmodule

module ace_snoop_buffer #(
  parameter int unsigned AcDepth     = 2,
  parameter int unsigned CdDepth     = 2,
  parameter int unsigned CrDepth     = 2,
  parameter int unsigned MaxOutstand = 0,
  parameter type ac_chan_t    = ace_snoop_pkg::ac_chan_t,
  parameter type cd_chan_t    = ace_snoop_pkg::cd_chan_t,
  parameter type cr_chan_t    = ace_snoop_pkg::cr_chan_t,
  parameter type snoop_req_t  = ace_snoop_pkg::snoop_req_t,
  parameter type snoop_resp_t = ace_snoop_pkg::snoop_resp_t,
  localparam int unsigned CntW = (MaxOutstand == 0) ? 1 : $clog2(MaxOutstand + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  snoop_req_t      slv_req_i,
  output snoop_resp_t     slv_resp_o,
  output snoop_req_t      mst_req_o,
  input  snoop_resp_t     mst_resp_i,
  output logic [CntW-1:0] outstand_o,
  output logic            idle_o,
  output logic            err_o
);
  logic     ac_fifo_ready, ac_push_valid, ac_below;
  logic     ac_out_valid, cd_out_valid, cr_out_valid;
  logic     cd_in_ready, cr_in_ready;
  logic     ac_empty, cd_empty, cr_empty;
  ac_chan_t ac_out;
  cd_chan_t cd_out;
  cr_chan_t cr_out;

  // Count moves up/down by one; a CR with nothing outstanding saturates at zero.
  function automatic logic [CntW-1:0] cnt_next(input logic [CntW-1:0] c,
                                               input logic up, input logic down);
    case ({up, down})
      2'b10:   return c + 1'b1;
      2'b01:   return (c == '0) ? c : c - 1'b1;
      default: return c;
    endcase
  endfunction

  assign ac_push_valid = slv_req_i.ac_valid && ac_below;

  ace_snoop_fifo #(.Depth(AcDepth), .T(ac_chan_t)) u_ac (
    .clk(clk_i), .rst(rst_i),
    .push_valid(ac_push_valid), .push_ready(ac_fifo_ready), .push_data(slv_req_i.ac),
    .pop_valid(ac_out_valid), .pop_ready(mst_resp_i.ac_ready), .pop_data(ac_out),
    .empty(ac_empty)
  );

  ace_snoop_fifo #(.Depth(CdDepth), .T(cd_chan_t)) u_cd (
    .clk(clk_i), .rst(rst_i),
    .push_valid(mst_resp_i.cd_valid), .push_ready(cd_in_ready), .push_data(mst_resp_i.cd),
    .pop_valid(cd_out_valid), .pop_ready(slv_req_i.cd_ready), .pop_data(cd_out),
    .empty(cd_empty)
  );

  ace_snoop_fifo #(.Depth(CrDepth), .T(cr_chan_t)) u_cr (
    .clk(clk_i), .rst(rst_i),
    .push_valid(mst_resp_i.cr_valid), .push_ready(cr_in_ready), .push_data(mst_resp_i.cr_resp),
    .pop_valid(cr_out_valid), .pop_ready(slv_req_i.cr_ready), .pop_data(cr_out),
    .empty(cr_empty)
  );

  if (MaxOutstand == 0) begin : g_nolimit
    assign ac_below   = 1'b1;
    assign outstand_o = '0;
    assign err_o      = 1'b0;
  end else begin : g_limit
    localparam logic [CntW-1:0] Limit = CntW'(MaxOutstand);
    logic [CntW-1:0] cnt;
    logic            err, inc, dec;

    assign inc = ac_push_valid && ac_fifo_ready;
    assign dec = cr_out_valid && slv_req_i.cr_ready;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        cnt <= '0;
        err <= 1'b0;
      end else begin
        cnt <= cnt_next(cnt, inc, dec);
        if (dec && cnt == '0) err <= 1'b1;
      end
    end

    assign ac_below   = (cnt < Limit);
    assign outstand_o = cnt;
    assign err_o      = err;
  end

  always_comb begin
    mst_req_o          = '0;
    mst_req_o.ac       = ac_out;
    mst_req_o.ac_valid = ac_out_valid;
    mst_req_o.cd_ready = cd_in_ready;
    mst_req_o.cr_ready = cr_in_ready;

    slv_resp_o          = '0;
    slv_resp_o.ac_ready = ac_fifo_ready && ac_below;
    slv_resp_o.cd       = cd_out;
    slv_resp_o.cd_valid = cd_out_valid;
    slv_resp_o.cr_resp  = cr_out;
    slv_resp_o.cr_valid = cr_out_valid;
  end

  assign idle_o = ac_empty && cd_empty && cr_empty && (outstand_o == '0);
endmodule
